// File: rtl/arith_enc_pkg.sv
// Shared types and constants for the arithmetic-encoder bitstream collector.
// Flag codes, collector FSM states and the default word width live here.
package arith_enc_pkg;

    localparam int ENC_WORD_WIDTH = 16;

    localparam logic [1:0] FLAG_NONE    = 2'd0;
    localparam logic [1:0] FLAG_ONE     = 2'd1;
    localparam logic [1:0] FLAG_TWO     = 2'd2;
    localparam logic [1:0] FLAG_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } collector_state_e;

    // Illegal code is treated like FLAG_TWO.
    function automatic logic [1:0] flag_words(input logic [1:0] f);
        logic [1:0] n;
        case (f)
            FLAG_NONE: n = 2'd0;
            FLAG_ONE:  n = 2'd1;
            default:   n = 2'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/arith_enc_lane_compactor.sv
// Combinational lane compactor: prefix-sums per-lane word counts into slot
// offsets and packs the valid words contiguously, lane 0 first.
module arith_enc_lane_compactor
    import arith_enc_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int WORD_WIDTH = ENC_WORD_WIDTH,
    parameter int NW         = $clog2(2*LANES+1)
) (
    input  logic [2*LANES-1:0]            flag_i,
    input  logic [LANES*WORD_WIDTH-1:0]   bit1_i,
    input  logic [LANES*WORD_WIDTH-1:0]   bit2_i,
    output logic [2*LANES*WORD_WIDTH-1:0] words_o,
    output logic [NW-1:0]                 nwrite_o,
    output logic                          illegal_o
);

    logic [NW-1:0] acc;
    logic [1:0]    cnt;
    logic [1:0]    f;

    always_comb begin
        words_o   = '0;
        illegal_o = 1'b0;
        acc       = '0;
        cnt       = '0;
        f         = '0;
        for (int i = 0; i < LANES; i++) begin
            f   = flag_i[2*i +: 2];
            cnt = flag_words(f);
            if (f == FLAG_ILLEGAL) begin
                illegal_o = 1'b1;
            end
            if (cnt != 2'd0) begin
                words_o[int'(acc)*WORD_WIDTH +: WORD_WIDTH] =
                    bit1_i[i*WORD_WIDTH +: WORD_WIDTH];
            end
            if (cnt == 2'd2) begin
                words_o[(int'(acc)+1)*WORD_WIDTH +: WORD_WIDTH] =
                    bit2_i[i*WORD_WIDTH +: WORD_WIDTH];
            end
            acc = acc + NW'(cnt);
        end
        nwrite_o = acc;
    end

endmodule

// File: rtl/arith_enc_bitstream_collector.sv
// LANES-wide pre-bitstream collector: compacting FIFO, valid/ready output,
// end-of-frame flush FSM. ENC_COLLECT_STATS_EN enables the popped-word counter.
module arith_enc_bitstream_collector
    import arith_enc_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int WORD_WIDTH = ENC_WORD_WIDTH,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH)+1
) (
    input  logic                        general_clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*LANES-1:0]          in_flag,
    input  logic [LANES*WORD_WIDTH-1:0] in_bit_1,
    input  logic [LANES*WORD_WIDTH-1:0] in_bit_2,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_WIDTH-1:0]       out_word,
    output logic                        out_last,
    output logic                        flush_done,
    output logic [CNT_WIDTH-1:0]        occupancy,
    output logic                        err_flag,
    output logic [31:0]                 word_count
);

    localparam int SLOTS = 2*LANES;
    localparam int NW    = $clog2(SLOTS+1);
    localparam int PW    = CNT_WIDTH-1;

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] SLOTS_C = CNT_WIDTH'(SLOTS);

    if (DEPTH < SLOTS || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_cfg
        $error("DEPTH must be a power of 2 and >= 2*LANES");
    end

    collector_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]    occ_q, occ_d;
    logic [CNT_WIDTH-1:0]    nwr_eff;
    logic [PW-1:0]           wptr_q, rptr_q;
    logic                    err_q;
    logic [WORD_WIDTH-1:0]   mem [DEPTH];
    logic [SLOTS*WORD_WIDTH-1:0] words;
    logic [NW-1:0]           nwrite;
    logic                    illegal;
    logic                    accept;
    logic                    pop;

    arith_enc_lane_compactor #(
        .LANES      (LANES),
        .WORD_WIDTH (WORD_WIDTH),
        .NW         (NW)
    ) u_compactor (
        .flag_i    (in_flag),
        .bit1_i    (in_bit_1),
        .bit2_i    (in_bit_2),
        .words_o   (words),
        .nwrite_o  (nwrite),
        .illegal_o (illegal)
    );

    // Worst-case reservation: a beat is admitted only if any flag mix fits.
    assign in_ready  = (state_q == ST_RUN) && ((DEPTH_C - occ_q) >= SLOTS_C);
    assign accept    = in_valid && in_ready;
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready;
    assign nwr_eff   = accept ? CNT_WIDTH'(nwrite) : '0;
    assign occ_d     = occ_q + nwr_eff - CNT_WIDTH'(pop);

    assign out_word   = mem[rptr_q];
    assign out_last   = (state_q == ST_DRAIN) && (occ_q == CNT_WIDTH'(1));
    assign flush_done = (state_q == ST_DONE);
    assign occupancy  = occ_q;
    assign err_flag   = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            occ_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            wptr_q  <= wptr_q + PW'(nwr_eff);
            rptr_q  <= rptr_q + PW'(pop);
            if (accept && illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge general_clk) begin
        for (int j = 0; j < SLOTS; j++) begin
            if (accept && (NW'(j) < nwrite)) begin
                mem[wptr_q + PW'(j)] <= words[j*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

`ifdef ENC_COLLECT_STATS_EN
    logic [31:0] wcnt_q;

    always_ff @(posedge general_clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= '0;
        end else if (state_q == ST_DONE) begin
            wcnt_q <= '0;
        end else if (pop && (wcnt_q != '1)) begin
            wcnt_q <= wcnt_q + 32'd1;
        end
    end

    assign word_count = wcnt_q;
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_arith_enc_bitstream_collector.sv
// Directed bench for arith_enc_bitstream_collector (LANES=3, DEPTH=16).
// Table-driven compaction vectors plus hand sequences for the corner cases.
module tb_arith_enc_bitstream_collector;

    localparam logic [15:0] L0B1 = 16'h0A01;
    localparam logic [15:0] L0B2 = 16'h0A02;
    localparam logic [15:0] L1B1 = 16'h1B01;
    localparam logic [15:0] L1B2 = 16'h1B02;
    localparam logic [15:0] L2B1 = 16'h2C01;
    localparam logic [15:0] L2B2 = 16'h2C02;

    logic        general_clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_flag;
    logic [47:0] in_bit_1;
    logic [47:0] in_bit_2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_last;
    logic        flush_done;
    logic [4:0]  occupancy;
    logic        err_flag;
    logic [31:0] word_count;

    int checks   = 0;
    int failures = 0;
    int exp_wc;

    typedef struct {
        logic [5:0]  flags;
        int          n;
        logic [95:0] w;
    } vec_t;

    vec_t tv [6];

    arith_enc_bitstream_collector dut (
        .general_clk (general_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_flag     (in_flag),
        .in_bit_1    (in_bit_1),
        .in_bit_2    (in_bit_2),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_last    (out_last),
        .flush_done  (flush_done),
        .occupancy   (occupancy),
        .err_flag    (err_flag),
        .word_count  (word_count)
    );

    initial general_clk = 1'b0;
    always #5 general_clk = ~general_clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge general_clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && occupancy != 0; i++) step();
        out_ready = 1'b0;
        chk("drain_empty", 32'(occupancy), 32'd0);
    endtask

    initial begin
        // slot 0 is the rightmost word of w
        tv[0] = '{6'b00_01_10, 3, {48'h0, L1B1, L0B2, L0B1}};
        tv[1] = '{6'b00_00_00, 0, 96'h0};
        tv[2] = '{6'b01_01_01, 3, {48'h0, L2B1, L1B1, L0B1}};
        tv[3] = '{6'b10_10_10, 6, {L2B2, L2B1, L1B2, L1B1, L0B2, L0B1}};
        tv[4] = '{6'b01_00_00, 1, {80'h0, L2B1}};
        tv[5] = '{6'b10_00_01, 3, {48'h0, L2B2, L2B1, L0B1}};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_flag   = '0;
        in_bit_1  = {L2B1, L1B1, L0B1};
        in_bit_2  = {L2B2, L1B2, L0B2};
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(flush_done), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        chk("rst_wc", word_count, 32'd0);
        reset = 1'b1;
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            in_flag  = tv[v].flags;
            in_valid = 1'b1;
            chk("cmp_ready", 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            chk("cmp_occ", 32'(occupancy), 32'(tv[v].n));
            chk("cmp_valid", 32'(out_valid), 32'(tv[v].n != 0));
            for (int k = 0; k < tv[v].n; k++) begin
                chk("cmp_word", 32'(out_word), 32'(tv[v].w[k*16 +: 16]));
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
            end
            chk("cmp_empty", 32'(occupancy), 32'd0);
        end

        in_flag  = 6'b10_10_10;
        in_valid = 1'b1;
        chk("bp_ready0", 32'(in_ready), 32'd1);
        step();
        chk("bp_occ6", 32'(occupancy), 32'd6);
        chk("bp_ready6", 32'(in_ready), 32'd1);
        step();
        chk("bp_occ12", 32'(occupancy), 32'd12);
        chk("bp_ready12", 32'(in_ready), 32'd0);
        step();
        chk("bp_hold12", 32'(occupancy), 32'd12);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_head", 32'(out_word), 32'(L0B1));
        step();
        chk("bp_occ11", 32'(occupancy), 32'd11);
        chk("bp_ready11", 32'(in_ready), 32'd0);
        step();
        chk("bp_occ10", 32'(occupancy), 32'd10);
        chk("bp_ready10", 32'(in_ready), 32'd1);
        drain();

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ef_ready", 32'(in_ready), 32'd0);
        chk("ef_done0", 32'(flush_done), 32'd0);
        step();
        chk("ef_done1", 32'(flush_done), 32'd1);
        chk("ef_last", 32'(out_last), 32'd0);
        step();
        chk("ef_done2", 32'(flush_done), 32'd0);
        chk("ef_ready2", 32'(in_ready), 32'd1);
        chk("ef_wc", word_count, 32'd0);

        in_flag  = 6'b00_00_10;
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("fl_pre_empty", 32'(occupancy), 32'd0);
        in_flag  = 6'b00_01_10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fl_occ3", 32'(occupancy), 32'd3);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_ready", 32'(in_ready), 32'd0);
        chk("fl_occ2", 32'(occupancy), 32'd2);
        chk("fl_last2", 32'(out_last), 32'd0);
        chk("fl_word2", 32'(out_word), 32'(L0B2));
        in_flag  = 6'b10_10_10;
        in_valid = 1'b1;
        step();
        chk("fl_occ1", 32'(occupancy), 32'd1);
        chk("fl_last1", 32'(out_last), 32'd1);
        chk("fl_word1", 32'(out_word), 32'(L1B1));
        out_ready = 1'b0;
        step();
        chk("fl_hold_occ", 32'(occupancy), 32'd1);
        chk("fl_hold_last", 32'(out_last), 32'd1);
        chk("fl_hold_word", 32'(out_word), 32'(L1B1));
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef ENC_COLLECT_STATS_EN
        exp_wc = 5;
`else
        exp_wc = 0;
`endif
        chk("fl_done", 32'(flush_done), 32'd1);
        chk("fl_occ0", 32'(occupancy), 32'd0);
        chk("fl_last0", 32'(out_last), 32'd0);
        chk("fl_wc5", word_count, 32'(exp_wc));
        chk("fl_ready_done", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        chk("fl_done_off", 32'(flush_done), 32'd0);
        chk("fl_ready_run", 32'(in_ready), 32'd1);
        chk("fl_wc_clr", word_count, 32'd0);

        in_flag  = 6'b00_11_00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("il_err", 32'(err_flag), 32'd1);
        chk("il_occ", 32'(occupancy), 32'd2);
        chk("il_w0", 32'(out_word), 32'(L1B1));
        out_ready = 1'b1;
        step();
        chk("il_w1", 32'(out_word), 32'(L1B2));
        step();
        out_ready = 1'b0;
        chk("il_empty", 32'(occupancy), 32'd0);
        in_flag  = 6'b01_01_01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("il_sticky", 32'(err_flag), 32'd1);
        chk("il_occ3", 32'(occupancy), 32'd3);

        #3;
        reset = 1'b0;
        #1;
        chk("ar_occ", 32'(occupancy), 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_err", 32'(err_flag), 32'd0);
        chk("ar_wc", word_count, 32'd0);
        @(negedge general_clk);
        reset = 1'b1;
        step();
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_occ_run", 32'(occupancy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
